// File: rtl/regfile_write_arbiter_if.sv
// Bus between the two writeback requesters, the hazard unit and the
// register-file write arbiter.
//   reqN_valid/ready/reg/value : one write offer per requester (N = 0 load, 1 ALU/CSR)
//   write_control              : registered {enable, which_register, value} to register_file
//   rs1/rs2, rsX_pending       : decode-stage source registers and their pending flags
// Modport slave is the arbiter side; master is the requester/hazard side.
interface regfile_write_arbiter_if #(
  parameter int XLEN = 32
);
  typedef struct packed {
    logic            enable;
    logic [4:0]      which_register;
    logic [XLEN-1:0] value;
  } reg_write_control_t;

  logic            req0_valid;
  logic            req0_ready;
  logic [4:0]      req0_reg;
  logic [XLEN-1:0] req0_value;

  logic            req1_valid;
  logic            req1_ready;
  logic [4:0]      req1_reg;
  logic [XLEN-1:0] req1_value;

  reg_write_control_t write_control;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_pending;
  logic            rs2_pending;

  modport master (
    output req0_valid, req0_reg, req0_value,
    output req1_valid, req1_reg, req1_value,
    output rs1, rs2,
    input  req0_ready, req1_ready, write_control, rs1_pending, rs2_pending
  );

  modport slave (
    input  req0_valid, req0_reg, req0_value,
    input  req1_valid, req1_reg, req1_value,
    input  rs1, rs2,
    output req0_ready, req1_ready, write_control, rs1_pending, rs2_pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two writeback
//   requesters (slot0 = load/memory, slot1 = ALU/CSR). Each requester owns a
//   one-entry holding slot; an aging fixed-priority arbiter drains one slot per
//   cycle. A granted write passes one in-flight stage and then appears on the
//   registered write_control, so an accept at edge N shows enable=1 after
//   edge N+2.
// Ports
//   clock  : rising-edge clock for all state
//   reset  : asynchronous, active-low; clears slots, age, starve counter, outputs
//   bus    : regfile_write_arbiter_if.slave (request handshakes, write_control,
//            rs1/rs2 and their pending flags)
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  regfile_write_arbiter_if.slave        bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  // Slot storage, index 0 = requester 0, index 1 = requester 1.
  logic [1:0]                held_q, held_d;
  logic [1:0][4:0]           reg_q, reg_d;
  logic [1:0][XLEN-1:0]      val_q, val_d;
  // age_q = 1 means slot1 holds the older write.
  logic                      age_q, age_d;
  logic [3:0]                starve_q, starve_d;

  // In-flight stage between the arbiter and write_control.
  logic                      fl_en_q, fl_en_d;
  logic [4:0]                fl_reg_q, fl_reg_d;
  logic [XLEN-1:0]           fl_val_q, fl_val_d;

  logic                      wc_en_q, wc_en_d;
  logic [4:0]                wc_reg_q, wc_reg_d;
  logic [XLEN-1:0]           wc_val_q, wc_val_d;

  logic [1:0]                in_valid;
  logic [1:0][4:0]           in_reg;
  logic [1:0][XLEN-1:0]      in_val;

  logic [1:0]                grant;
  logic [1:0]                ready;
  logic [1:0]                accept;
  logic [1:0]                fill;
  logic [1:0]                stays;
  logic [1:0]                match_rs1;
  logic [1:0]                match_rs2;

  assign in_valid = {bus.req1_valid, bus.req0_valid};
  assign in_reg   = {bus.req1_reg,   bus.req0_reg};
  assign in_val   = {bus.req1_value, bus.req0_value};

  // Arbitration over held slots. A same-register pair must drain oldest first
  // so the register ends with the newest value; that rule outranks the
  // anti-starvation rule.
  always_comb begin
    grant = 2'b00;
    if (held_q[0] && !held_q[1]) begin
      grant = 2'b01;
    end else if (!held_q[0] && held_q[1]) begin
      grant = 2'b10;
    end else if (held_q[0] && held_q[1]) begin
      if (reg_q[0] == reg_q[1]) begin
        grant = age_q ? 2'b10 : 2'b01;
      end else if (starve_q == STARVE_MAX) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    // Ready also while the slot drains, so an uncontended requester can
    // stream one write per cycle. Forced low while reset is asserted.
    assign ready[gi]  = reset & (~held_q[gi] | grant[gi]);
    assign accept[gi] = in_valid[gi] & ready[gi];
    // Writes to x0 complete the handshake but are simply dropped.
    assign fill[gi]   = accept[gi] & (in_reg[gi] != 5'd0);
    assign stays[gi]  = held_q[gi] & ~grant[gi];
    assign held_d[gi] = fill[gi] | stays[gi];
    assign reg_d[gi]  = fill[gi] ? in_reg[gi] : reg_q[gi];
    assign val_d[gi]  = fill[gi] ? in_val[gi] : val_q[gi];
    assign match_rs1[gi] = held_q[gi] & (reg_q[gi] == bus.rs1);
    assign match_rs2[gi] = held_q[gi] & (reg_q[gi] == bus.rs2);
  end

  // Age: a new fill is younger than a slot that keeps its old contents.
  // When both slots fill on the same edge, requester 0 counts as earlier.
  always_comb begin
    age_d = age_q;
    if (fill[0] && fill[1]) begin
      age_d = 1'b0;
    end else if (fill[0] && stays[1]) begin
      age_d = 1'b1;
    end else if (fill[1] && stays[0]) begin
      age_d = 1'b0;
    end
  end

  // Counts consecutive cycles slot1 waited while held; saturates at the limit.
  always_comb begin
    starve_d = 4'd0;
    if (stays[1]) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end
  end

  // Write path: grant -> in-flight stage -> write_control. Register and value
  // hold their last contents whenever enable is low.
  always_comb begin
    fl_en_d  = |grant;
    fl_reg_d = fl_reg_q;
    fl_val_d = fl_val_q;
    if (grant[1]) begin
      fl_reg_d = reg_q[1];
      fl_val_d = val_q[1];
    end else if (grant[0]) begin
      fl_reg_d = reg_q[0];
      fl_val_d = val_q[0];
    end
    wc_en_d  = fl_en_q;
    wc_reg_d = wc_reg_q;
    wc_val_d = wc_val_q;
    if (fl_en_q) begin
      wc_reg_d = fl_reg_q;
      wc_val_d = fl_val_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_q   <= '0;
      reg_q    <= '0;
      val_q    <= '0;
      age_q    <= 1'b0;
      starve_q <= 4'd0;
      fl_en_q  <= 1'b0;
      fl_reg_q <= 5'd0;
      fl_val_q <= '0;
      wc_en_q  <= 1'b0;
      wc_reg_q <= 5'd0;
      wc_val_q <= '0;
    end else begin
      held_q   <= held_d;
      reg_q    <= reg_d;
      val_q    <= val_d;
      age_q    <= age_d;
      starve_q <= starve_d;
      fl_en_q  <= fl_en_d;
      fl_reg_q <= fl_reg_d;
      fl_val_q <= fl_val_d;
      wc_en_q  <= wc_en_d;
      wc_reg_q <= wc_reg_d;
      wc_val_q <= wc_val_d;
    end
  end

  assign bus.req0_ready    = ready[0];
  assign bus.req1_ready    = ready[1];
  assign bus.write_control = {wc_en_q, wc_reg_q, wc_val_q};

  // A register is pending while its write sits in a slot, in the in-flight
  // stage, or on write_control. x0 is never pending.
  assign bus.rs1_pending = (bus.rs1 != 5'd0) &
                           ((|match_rs1) |
                            (fl_en_q & (fl_reg_q == bus.rs1)) |
                            (wc_en_q & (wc_reg_q == bus.rs1)));
  assign bus.rs2_pending = (bus.rs2 != 5'd0) &
                           ((|match_rs2) |
                            (fl_en_q & (fl_reg_q == bus.rs2)) |
                            (wc_en_q & (wc_reg_q == bus.rs2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations plus randomized traffic compared every cycle against a
// behavioural model (sequence-numbered slots and a two-deep write delay line).
module tb_regfile_write_arbiter;
  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.XLEN(XLEN)) bus();

  regfile_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  // ---------------- model ----------------
  bit          m_held [2];
  logic [4:0]  m_reg  [2];
  logic [31:0] m_val  [2];
  int          m_seq  [2];
  int          seq_ctr = 0;
  int          m_lost  = 0;
  bit          m_st_en = 1'b0;
  logic [4:0]  m_st_reg = 5'd0;
  logic [31:0] m_st_val = 32'd0;
  bit          m_wc_en = 1'b0;
  logic [4:0]  m_wc_reg = 5'd0;
  logic [31:0] m_wc_val = 32'd0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_held[i] = 1'b0;
      m_reg[i]  = 5'd0;
      m_val[i]  = 32'd0;
    end
    m_lost   = 0;
    m_st_en  = 1'b0;
    m_st_reg = 5'd0;
    m_st_val = 32'd0;
    m_wc_en  = 1'b0;
    m_wc_reg = 5'd0;
    m_wc_val = 32'd0;
  endtask

  function automatic int model_grant();
    if (m_held[0] && m_held[1]) begin
      if (m_reg[0] == m_reg[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      if (m_lost >= LIMIT) return 1;
      return 0;
    end
    if (m_held[0]) return 0;
    if (m_held[1]) return 1;
    return -1;
  endfunction

  function automatic bit model_pending(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_held[i] && m_reg[i] == rs) return 1'b1;
    if (m_st_en && m_st_reg == rs) return 1'b1;
    if (m_wc_en && m_wc_reg == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int          g;
    bit          acc [2];
    bit          vin [2];
    logic [4:0]  rin [2];
    logic [31:0] din [2];
    if (!reset) begin
      model_reset();
      return;
    end
    vin[0] = bus.req0_valid; rin[0] = bus.req0_reg; din[0] = bus.req0_value;
    vin[1] = bus.req1_valid; rin[1] = bus.req1_reg; din[1] = bus.req1_value;
    g = model_grant();
    for (int i = 0; i < 2; i++) acc[i] = vin[i] && (!m_held[i] || g == i);
    m_wc_en = m_st_en;
    if (m_st_en) begin
      m_wc_reg = m_st_reg;
      m_wc_val = m_st_val;
    end
    m_st_en = (g >= 0);
    if (m_held[1] && g != 1) m_lost++;
    else m_lost = 0;
    if (g >= 0) begin
      m_st_reg  = m_reg[g];
      m_st_val  = m_val[g];
      m_held[g] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i] && rin[i] != 5'd0) begin
        m_held[i] = 1'b1;
        m_reg[i]  = rin[i];
        m_val[i]  = din[i];
        m_seq[i]  = seq_ctr;
        seq_ctr++;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int g;
    g = model_grant();
    check("ready0", 64'(bus.req0_ready), 64'(reset && (!m_held[0] || g == 0)));
    check("ready1", 64'(bus.req1_ready), 64'(reset && (!m_held[1] || g == 1)));
    check("wc_enable", 64'(bus.write_control.enable), 64'(m_wc_en));
    check("wc_reg", 64'(bus.write_control.which_register), 64'(m_wc_reg));
    check("wc_value", 64'(bus.write_control.value), 64'(m_wc_val));
    check("rs1_pending", 64'(bus.rs1_pending), 64'(model_pending(bus.rs1)));
    check("rs2_pending", 64'(bus.rs2_pending), 64'(model_pending(bus.rs2)));
  endtask

  // One clock: compare with inputs settled, step the model at the edge,
  // return shortly after the following falling edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clock);
    model_step();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_value = d0;
    bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_value = d1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- register-file image and write log ----------------
  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
    int          cyc;
  } wr_t;
  wr_t         wlog [$];
  logic [31:0] rf [32];
  int          cyc = 0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (bus.write_control.enable === 1'b1) begin
      wlog.push_back('{bus.write_control.which_register, bus.write_control.value, cyc});
      rf[bus.write_control.which_register] <= bus.write_control.value;
      $display("[TB] write x%0d <= %08h", bus.write_control.which_register, bus.write_control.value);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n12;
    model_reset();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    drive(1'b1, 5'd5, 32'hCAFEBABE, 1'b0, 5'd0, 32'd0);

    // 1. reset state, then first write latency
    @(negedge clock);
    #1;
    check("t1_rst_enable", 64'(bus.write_control.enable), 64'd0);
    check("t1_rst_reg", 64'(bus.write_control.which_register), 64'd0);
    check("t1_rst_value", 64'(bus.write_control.value), 64'd0);
    check("t1_rst_ready0", 64'(bus.req0_ready), 64'd0);
    check("t1_rst_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    reset = 1'b1;
    #1;
    check("t1_ready0_after_reset", 64'(bus.req0_ready), 64'd1);
    tick();                                   // accept edge N
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t1_enable_after_N", 64'(bus.write_control.enable), 64'd0);
    tick();                                   // edge N+1
    check("t1_enable_after_N1", 64'(bus.write_control.enable), 64'd0);
    tick();                                   // edge N+2
    check("t1_enable_after_N2", 64'(bus.write_control.enable), 64'd1);
    check("t1_reg", 64'(bus.write_control.which_register), 64'd5);
    check("t1_value", 64'(bus.write_control.value), 64'hCAFEBABE);
    idle(4);
    wlog.delete();

    // 2. simultaneous requests, slot0 first
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check("t2_ready1_blocked", 64'(bus.req1_ready), 64'd0);
    check("t2_ready0_draining", 64'(bus.req0_ready), 64'd1);
    tick();
    check("t2_ready1_back", 64'(bus.req1_ready), 64'd1);
    idle(4);
    check("t2_count", 64'(wlog.size()), 64'd2);
    if (wlog.size() >= 2) begin
      check("t2_first_reg", 64'(wlog[0].r), 64'd3);
      check("t2_first_val", 64'(wlog[0].v), 64'h11);
      check("t2_second_reg", 64'(wlog[1].r), 64'd4);
      check("t2_second_val", 64'(wlog[1].v), 64'h22);
      check("t2_consecutive", 64'(wlog[1].cyc - wlog[0].cyc), 64'd1);
    end
    wlog.delete();

    // 3. same register: older slot1 value written first
    drive(1'b1, 5'd8, 32'h1, 1'b1, 5'd7, 32'hA);
    tick();
    drive(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0);
    #1;
    check("t3_ready0", 64'(bus.req0_ready), 64'd1);
    check("t3_ready1", 64'(bus.req1_ready), 64'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    check("t3_older_slot1_granted", 64'(bus.req1_ready), 64'd1);
    check("t3_slot0_waits", 64'(bus.req0_ready), 64'd0);
    idle(5);
    check("t3_count", 64'(wlog.size()), 64'd3);
    if (wlog.size() >= 3) begin
      check("t3_w1_reg", 64'(wlog[1].r), 64'd7);
      check("t3_w1_val", 64'(wlog[1].v), 64'hA);
      check("t3_w2_val", 64'(wlog[2].v), 64'hB);
    end
    check("t3_final_r7", 64'(rf[7]), 64'hB);
    wlog.delete();

    // 4. starvation: r9 wins on the 5th contended cycle
    drive(1'b1, 5'd20, 32'd0, 1'b1, 5'd9, 32'h99);
    tick();
    for (int k = 1; k <= 7; k++) begin
      drive(1'b1, 5'(20 + k), 32'(k), 1'b0, 5'd0, 32'd0);
      #1;
      if (k <= 4) check("t4_slot1_loses", 64'(bus.req1_ready), 64'd0);
      if (k == 5) begin
        check("t4_slot1_wins", 64'(bus.req1_ready), 64'd1);
        check("t4_slot0_blocked", 64'(bus.req0_ready), 64'd0);
      end
      tick();
    end
    idle(4);
    check("t4_count", 64'(wlog.size()), 64'd8);
    if (wlog.size() >= 6) begin
      check("t4_w3_reg", 64'(wlog[3].r), 64'd23);
      check("t4_w4_reg", 64'(wlog[4].r), 64'd9);
      check("t4_w4_val", 64'(wlog[4].v), 64'h99);
      check("t4_w5_reg", 64'(wlog[5].r), 64'd24);
    end
    wlog.delete();

    // 5. x0 write completes handshake but never reaches write_control
    bus.rs1 = 5'd0;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    #1;
    check("t5_ready0", 64'(bus.req0_ready), 64'd1);
    check("t5_rs1_pending", 64'(bus.rs1_pending), 64'd0);
    tick();
    idle(4);
    check("t5_no_write", 64'(wlog.size()), 64'd0);
    check("t5_rs1_pending_after", 64'(bus.rs1_pending), 64'd0);

    // 6a. pending tracks r12 through slot, in-flight stage and write_control
    bus.rs2 = 5'd12;
    drive(1'b1, 5'd12, 32'h1212, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("t6_pending_held", 64'(bus.rs2_pending), 64'd1);
    tick();
    check("t6_pending_flight", 64'(bus.rs2_pending), 64'd1);
    tick();
    check("t6_pending_wc", 64'(bus.rs2_pending), 64'd1);
    check("t6_enable_wc", 64'(bus.write_control.enable), 64'd1);
    tick();
    check("t6_enable_dropped", 64'(bus.write_control.enable), 64'd0);
    check("t6_pending_cleared", 64'(bus.rs2_pending), 64'd0);
    idle(2);
    wlog.delete();

    // 6b. asynchronous reset discards r12 while r11 is on write_control
    drive(1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b1, 5'd12, 32'h1213, 1'b0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    check("t6b_pending_before", 64'(bus.rs2_pending), 64'd1);
    check("t6b_enable_before", 64'(bus.write_control.enable), 64'd1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("t6b_enable_async", 64'(bus.write_control.enable), 64'd0);
    check("t6b_pending_async", 64'(bus.rs2_pending), 64'd0);
    check("t6b_ready_in_reset", 64'(bus.req0_ready), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    idle(5);
    n12 = 0;
    foreach (wlog[i]) if (wlog[i].r == 5'd12) n12++;
    check("t6b_r12_never_written", 64'(n12), 64'd0);
    wlog.delete();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
